// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_ctrl_pkg
// Brief  : Function codes and FSM state encoding for the ALU issue stage.
// Rev    : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

    localparam int FUNC_W = 4;
    localparam int CNT_W  = 4;

    localparam logic [FUNC_W-1:0] FUNC_AND = 4'd0;
    localparam logic [FUNC_W-1:0] FUNC_OR  = 4'd1;
    localparam logic [FUNC_W-1:0] FUNC_XOR = 4'd2;
    localparam logic [FUNC_W-1:0] FUNC_ADD = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_ctrl_dec
// Brief  : Function code to one-hot unit enable decoder with range flag.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl_dec
    import alu_issue_ctrl_pkg::*;
#(
    parameter int NUM_UNITS = 16
) (
    input  logic [FUNC_W-1:0]    func_i,
    output logic [NUM_UNITS-1:0] onehot_o,
    output logic                 invalid_o
);

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_onehot
        assign onehot_o[i] = (func_i == FUNC_W'(i));
    end

    // With a full 16-unit complement every 4-bit code is legal.
    if (NUM_UNITS >= (1 << FUNC_W)) begin : g_full
        assign invalid_o = 1'b0;
    end else begin : g_part
        assign invalid_o = (32'(func_i) >= 32'(NUM_UNITS));
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_ctrl
// Brief  : Issue/capture stage driving one-hot enables to the 16-bit ALU units.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_UNITS   = 16,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FUNC_W-1:0]    in_func,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [NUM_UNITS-1:0] unit_en,
    output logic [WIDTH-1:0]     unit_a,
    output logic [WIDTH-1:0]     unit_b,
    input  logic [WIDTH-1:0]     unit_c,
    input  logic                 unit_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_c,
    output logic                 out_ovf,
    output logic                 out_err,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FUNC_W-1:0]    func_q;
    logic [WIDTH-1:0]     a_q, b_q, c_q;
    logic                 ovf_q, err_q;
    logic [NUM_UNITS-1:0] dec_onehot;
    logic                 dec_invalid;
    logic                 accept;
    logic                 capture;

    alu_issue_ctrl_dec #(
        .NUM_UNITS (NUM_UNITS)
    ) u_dec (
        .func_i    (func_q),
        .onehot_o  (dec_onehot),
        .invalid_o (dec_invalid)
    );

    assign in_ready = !reset && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    cnt_d   = CNT_INIT;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // A simultaneous accept restarts execution without an idle bubble.
                if (out_ready) begin
                    if (accept) begin
                        state_d = EXEC;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            func_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                func_q <= in_func;
                a_q    <= in_a;
                b_q    <= in_b;
            end
            if (capture) begin
                c_q   <= dec_invalid ? '0 : unit_c;
                ovf_q <= dec_invalid ? 1'b0 : unit_ovf;
                err_q <= dec_invalid;
            end
        end
    end

    // Enables are gated to EXEC so the OR-combined unit_c only carries the selected unit.
    assign unit_en   = (state_q == EXEC) ? dec_onehot : '0;
    assign unit_a    = a_q;
    assign unit_b    = b_q;
    assign out_valid = (state_q == DONE);
    assign out_c     = c_q;
    assign out_ovf   = ovf_q;
    assign out_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_issue_ctrl
// Brief  : Directed self-checking bench; dut1 has 16 units / 1 exec cycle,
//          dut3 has 12 units / 3 exec cycles so out-of-range codes exist.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_func = '0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_ready = 1'b0;
    logic        force_ones = 1'b0;

    logic        in_ready1, out_valid1, out_ovf1, out_err1, busy1, unit_ovf1;
    logic [15:0] unit_en1, unit_a1, unit_b1, unit_c1, out_c1;
    logic        in_ready3, out_valid3, out_ovf3, out_err3, busy3, unit_ovf3;
    logic [11:0] unit_en3;
    logic [15:0] unit_a3, unit_b3, unit_c3, out_c3;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Stand-in for the OR-combined functional units.
    function automatic logic [16:0] unit_model(input logic [15:0] en, input logic [15:0] a,
                                               input logic [15:0] b, input logic f1);
        logic [15:0] c;
        logic        v;
        logic [15:0] s;
        c = '0;
        v = 1'b0;
        s = a + b;
        if (en[FUNC_AND]) c = c | (a & b);
        if (en[FUNC_OR])  c = c | (a | b);
        if (en[FUNC_XOR]) c = c | (a ^ b);
        if (en[FUNC_ADD]) begin
            c = c | s;
            v = (a[15] == b[15]) && (s[15] != a[15]);
        end
        if (f1) begin
            c = 16'hFFFF;
            v = 1'b1;
        end
        return {v, c};
    endfunction

    always_comb {unit_ovf1, unit_c1} = unit_model(unit_en1, unit_a1, unit_b1, force_ones);
    always_comb {unit_ovf3, unit_c3} = unit_model({4'b0, unit_en3}, unit_a3, unit_b3, force_ones);

    alu_issue_ctrl #(.WIDTH(16), .NUM_UNITS(16), .EXEC_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_func(in_func), .in_a(in_a), .in_b(in_b), .unit_en(unit_en1),
        .unit_a(unit_a1), .unit_b(unit_b1), .unit_c(unit_c1), .unit_ovf(unit_ovf1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_c(out_c1),
        .out_ovf(out_ovf1), .out_err(out_err1), .busy(busy1)
    );

    alu_issue_ctrl #(.WIDTH(16), .NUM_UNITS(12), .EXEC_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
        .in_func(in_func), .in_a(in_a), .in_b(in_b), .unit_en(unit_en3),
        .unit_a(unit_a3), .unit_b(unit_b3), .unit_c(unit_c3), .unit_ovf(unit_ovf3),
        .out_valid(out_valid3), .out_ready(out_ready), .out_c(out_c3),
        .out_ovf(out_ovf3), .out_err(out_err3), .busy(busy3)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        in_func = FUNC_OR;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if ({in_ready1, out_valid1, busy1, in_ready3, out_valid3, busy3} !== 6'b0) begin
                fails++;
                $display("FAIL reset_ctrl: got %b expected 000000",
                         {in_ready1, out_valid1, busy1, in_ready3, out_valid3, busy3});
            end
            tests_run++;
            if (unit_en1 !== 16'h0 || unit_en3 !== 12'h0) begin
                fails++;
                $display("FAIL reset_en: got %h/%h expected 0/0", unit_en1, unit_en3);
            end
        end
        tests_run++;
        if (out_c1 !== 16'h0 || out_err1 !== 1'b0 || out_ovf1 !== 1'b0 || unit_a1 !== 16'h0) begin
            fails++;
            $display("FAIL reset_regs: got c=%h err=%b ovf=%b a=%h expected 0", out_c1, out_err1,
                     out_ovf1, unit_a1);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready1 !== 1'b1 || in_ready3 !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b%b expected 11", in_ready1, in_ready3);
        end
    endtask

    task automatic test_or();
        do_reset();
        in_valid = 1'b1;
        in_func = FUNC_OR;
        in_a = 16'h00F0;
        in_b = 16'h0F01;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL or_ready: got %b expected 1", in_ready1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (unit_en1 !== 16'h0002 || out_valid1 !== 1'b0 || busy1 !== 1'b1 || unit_a1 !== 16'h00F0) begin
            fails++;
            $display("FAIL or_exec: got en=%h v=%b busy=%b a=%h expected en=0002 v=0 busy=1 a=00f0",
                     unit_en1, out_valid1, busy1, unit_a1);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid1 !== 1'b1 || out_c1 !== 16'h0FF1 || out_ovf1 !== 1'b0 || out_err1 !== 1'b0
            || unit_en1 !== 16'h0) begin
            fails++;
            $display("FAIL or_result: got v=%b c=%h ovf=%b err=%b en=%h expected v=1 c=0ff1 0 0 en=0",
                     out_valid1, out_c1, out_ovf1, out_err1, unit_en1);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL or_drain: got v=%b busy=%b expected 0 0", out_valid1, busy1);
        end
    endtask

    task automatic test_stall();
        do_reset();
        in_valid = 1'b1;
        in_func = FUNC_ADD;
        in_a = 16'h7FFF;
        in_b = 16'h0001;
        out_ready = 1'b0;
        @(negedge clk);
        in_func = FUNC_XOR;
        in_a = 16'h1234;
        in_b = 16'h00FF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            tests_run++;
            if (out_valid1 !== 1'b1 || out_c1 !== 16'h8000 || out_ovf1 !== 1'b1 || in_ready1 !== 1'b0
                || unit_en1 !== 16'h0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got v=%b c=%h ovf=%b rdy=%b en=%h expected 1 8000 1 0 0",
                         i, out_valid1, out_c1, out_ovf1, in_ready1, unit_en1);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL stall_release_ready: got %b expected 1", in_ready1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (unit_en1 !== 16'h0004 || out_valid1 !== 1'b0) begin
            fails++;
            $display("FAIL stall_next_exec: got en=%h v=%b expected 0004 0", unit_en1, out_valid1);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid1 !== 1'b1 || out_c1 !== 16'h12CB || out_ovf1 !== 1'b0) begin
            fails++;
            $display("FAIL stall_next_result: got v=%b c=%h ovf=%b expected 1 12cb 0",
                     out_valid1, out_c1, out_ovf1);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  fn [4];
        logic [15:0] av [4];
        logic [15:0] bv [4];
        logic [15:0] ev [4];
        int          sent;
        int          got;
        int          en_cnt;
        int          last_t;
        fn = '{FUNC_OR, FUNC_AND, FUNC_XOR, FUNC_ADD};
        av = '{16'h00F0, 16'hF0F0, 16'hAAAA, 16'h1234};
        bv = '{16'h0F01, 16'hFF00, 16'hFFFF, 16'h1111};
        ev = '{16'h0FF1, 16'hF000, 16'h5555, 16'h2345};
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_func = fn[0];
        in_a = av[0];
        in_b = bv[0];
        sent = 1;
        got = 0;
        en_cnt = 0;
        last_t = 0;
        for (int t = 1; t <= 40 && got < 4; t++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid3) begin
                tests_run++;
                if (out_c3 !== ev[got] || out_ovf3 !== 1'b0 || en_cnt != 3 || (got > 0 && t - last_t != 4)) begin
                    fails++;
                    $display("FAIL b2b_result[%0d]: got c=%h ovf=%b pulse=%0d gap=%0d expected c=%h ovf=0 pulse=3 gap=4",
                             got, out_c3, out_ovf3, en_cnt, t - last_t, ev[got]);
                end
                got++;
                last_t = t;
                en_cnt = 0;
                if (sent < 4) begin
                    in_valid = 1'b1;
                    in_func = fn[sent];
                    in_a = av[sent];
                    in_b = bv[sent];
                    sent++;
                end
            end else if (unit_en3 != 12'h0) begin
                tests_run++;
                if (unit_en3 !== 12'(16'h1 << fn[got])) begin
                    fails++;
                    $display("FAIL b2b_en[%0d]: got %h expected %h", got, unit_en3, 12'(16'h1 << fn[got]));
                end
                en_cnt++;
            end
        end
        tests_run++;
        if (got != 4) begin
            fails++;
            $display("FAIL b2b_count: got %0d results expected 4", got);
        end
    endtask

    task automatic test_invalid();
        do_reset();
        force_ones = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_func = 4'd12;
        in_a = 16'h1111;
        in_b = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (unit_en1 !== 16'h1000) begin
            fails++;
            $display("FAIL inv_full_en: got %h expected 1000", unit_en1);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (unit_en3 !== 12'h0 || out_valid3 !== 1'b0 || busy3 !== 1'b1) begin
                fails++;
                $display("FAIL inv_exec[%0d]: got en=%h v=%b busy=%b expected 0 0 1", i, unit_en3,
                         out_valid3, busy3);
            end
            @(negedge clk);
        end
        tests_run++;
        if (out_valid3 !== 1'b1 || out_c3 !== 16'h0 || out_ovf3 !== 1'b0 || out_err3 !== 1'b1) begin
            fails++;
            $display("FAIL inv_result: got v=%b c=%h ovf=%b err=%b expected 1 0000 0 1",
                     out_valid3, out_c3, out_ovf3, out_err3);
        end
        force_ones = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_func = FUNC_OR;
        in_a = 16'h00F0;
        in_b = 16'h0F01;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (unit_en3 !== 12'h0 || busy3 !== 1'b0 || out_valid3 !== 1'b0 || in_ready3 !== 1'b0
            || out_c3 !== 16'h0) begin
            fails++;
            $display("FAIL midrst_state: got en=%h busy=%b v=%b rdy=%b c=%h expected 0 0 0 0 0",
                     unit_en3, busy3, out_valid3, in_ready3, out_c3);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
                fails++;
                $display("FAIL midrst_no_result[%0d]: got v=%b busy=%b expected 0 0", i, out_valid3, busy3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_or();
        test_stall();
        test_back_to_back();
        test_invalid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
